// File: rtl/lv_ow_adc_req_arb.sv
// lv_ow_adc_req_arb
// Serialises ADC-sample requests from the control FSM, the SPI host and an
// optional periodic poller onto the single OW request/ack channel, with
// retries on errored or timed-out transfers and a sticky timeout flag.
// Optional feature macro: LV_ADC_PRD_POLL_EN (periodic poller and prd source).
module lv_ow_adc_req_arb #(
  parameter int RETRY_NUM   = 3,
  parameter int ACK_TMO_CYC = 255,
  parameter int PRD_CYC     = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_fsm_req,
  output logic o_fsm_ack,
  input  logic i_spi_req,
  output logic o_spi_ack,
  input  logic i_prd_en,
  output logic o_prd_ack,
  output logic o_ack_status,
  output logic o_ow_req,
  input  logic i_ow_ack,
  input  logic i_ow_ack_status,
  output logic o_busy,
  output logic o_tmo_err,
  input  logic i_err_clr
);

  localparam int TMO_W = $clog2(ACK_TMO_CYC);
  localparam logic [3:0]       RETRY_MAX = 4'(RETRY_NUM);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TMO_CYC - 1);
  localparam logic [1:0] G_FSM = 2'd0;
  localparam logic [1:0] G_SPI = 2'd1;
  localparam logic [1:0] G_PRD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [2:0]       pend_q, pend_d;      // bit0 fsm, bit1 spi, bit2 prd
  logic [2:0]       pend_clr;
  logic [3:0]       retry_q, retry_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             status_q, status_d;
  logic             tmo_err_q, tmo_err_d;
  logic             ow_req_q, ow_req_d;
  logic             fsm_ack_q, fsm_ack_d;
  logic             spi_ack_q, spi_ack_d;
  logic             ack_status_q, ack_status_d;
  logic             busy_q, busy_d;
  logic             prd_set;             // poller terminal count this cycle
  logic             prd_drop;            // force prd pending low
  logic [1:0]       grant_pick;

`ifdef LV_ADC_PRD_POLL_EN
  localparam int PRD_W = $clog2(PRD_CYC);
  localparam logic [PRD_W-1:0] PRD_LAST = PRD_W'(PRD_CYC - 1);

  logic [PRD_W-1:0] prd_cnt_q, prd_cnt_d;
  logic             prd_ack_q, prd_ack_d;

  // Poll interval counter; halts while a poll is queued, in-flight prd survives disable
  always_comb begin
    prd_cnt_d = prd_cnt_q;
    prd_set   = 1'b0;
    prd_drop  = 1'b0;
    prd_ack_d = (state_q == DONE) && (grant_q == G_PRD);
    if (!i_prd_en) begin
      prd_cnt_d = '0;
      prd_drop  = !((state_q != IDLE) && (grant_q == G_PRD));
    end else if (!pend_q[2]) begin
      if (prd_cnt_q == PRD_LAST) begin
        prd_set   = 1'b1;
        prd_cnt_d = '0;
      end else begin
        prd_cnt_d = prd_cnt_q + PRD_W'(1);
      end
    end
  end

  // Poller registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prd_cnt_q <= '0;
      prd_ack_q <= 1'b0;
    end else begin
      prd_cnt_q <= prd_cnt_d;
      prd_ack_q <= prd_ack_d;
    end
  end

  assign o_prd_ack = prd_ack_q;
`else
  logic unused_prd_en;
  assign unused_prd_en = i_prd_en;
  assign prd_set       = 1'b0;
  assign prd_drop      = 1'b1;
  assign o_prd_ack     = 1'b0;
`endif

  // Pending bits, fixed-priority pick and transfer FSM next state / outputs
  always_comb begin
    pend_clr = (state_q == DONE) ? (3'b001 << grant_q) : 3'b000;
    pend_d   = (pend_q & ~pend_clr) | {prd_set, i_spi_req, i_fsm_req};
    if (prd_drop) pend_d[2] = 1'b0;
    grant_pick = pend_d[0] ? G_FSM : (pend_d[1] ? G_SPI : G_PRD);

    state_d   = state_q;
    grant_d   = grant_q;
    retry_d   = retry_q;
    tmo_cnt_d = tmo_cnt_q;
    status_d  = status_q;
    tmo_err_d = i_err_clr ? 1'b0 : tmo_err_q;

    unique case (state_q)
      IDLE: begin
        if (|pend_d) begin
          grant_d = grant_pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (i_ow_ack && !i_ow_ack_status) begin
          status_d = 1'b0;
          state_d  = DONE;
        end else if (i_ow_ack || (tmo_cnt_q == TMO_LAST)) begin
          if (!i_ow_ack) tmo_err_d = 1'b1;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = ISSUE;
          end else begin
            status_d = 1'b1;
            state_d  = DONE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      DONE: begin
        retry_d = '0;
        // Go straight to the next queued transfer without an IDLE bubble
        if (|pend_d) begin
          grant_d = grant_pick;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ow_req_d     = (state_q == ISSUE);
    fsm_ack_d    = (state_q == DONE) && (grant_q == G_FSM);
    spi_ack_d    = (state_q == DONE) && (grant_q == G_SPI);
    ack_status_d = (state_q == DONE) && status_q;
    busy_d       = (state_q != IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= G_FSM;
      pend_q       <= '0;
      retry_q      <= '0;
      tmo_cnt_q    <= '0;
      status_q     <= 1'b0;
      tmo_err_q    <= 1'b0;
      ow_req_q     <= 1'b0;
      fsm_ack_q    <= 1'b0;
      spi_ack_q    <= 1'b0;
      ack_status_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      pend_q       <= pend_d;
      retry_q      <= retry_d;
      tmo_cnt_q    <= tmo_cnt_d;
      status_q     <= status_d;
      tmo_err_q    <= tmo_err_d;
      ow_req_q     <= ow_req_d;
      fsm_ack_q    <= fsm_ack_d;
      spi_ack_q    <= spi_ack_d;
      ack_status_q <= ack_status_d;
      busy_q       <= busy_d;
    end
  end

  assign o_ow_req     = ow_req_q;
  assign o_fsm_ack    = fsm_ack_q;
  assign o_spi_ack    = spi_ack_q;
  assign o_ack_status = ack_status_q;
  assign o_busy       = busy_q;
  assign o_tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_lv_ow_adc_req_arb.sv
// Directed bench for lv_ow_adc_req_arb (RETRY_NUM=3, ACK_TMO_CYC=8, PRD_CYC=20).
module tb_lv_ow_adc_req_arb;
  localparam int RETRY_NUM   = 3;
  localparam int ACK_TMO_CYC = 8;
  localparam int PRD_CYC     = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fsm_req = 1'b0, spi_req = 1'b0, prd_en = 1'b0;
  logic ow_ack = 1'b0, ow_ack_status = 1'b0, err_clr = 1'b0;
  logic fsm_ack, spi_ack, prd_ack, ack_status, ow_req, busy, tmo_err;

  always #5 clk = ~clk;

  lv_ow_adc_req_arb #(
    .RETRY_NUM(RETRY_NUM), .ACK_TMO_CYC(ACK_TMO_CYC), .PRD_CYC(PRD_CYC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fsm_req(fsm_req), .o_fsm_ack(fsm_ack),
    .i_spi_req(spi_req), .o_spi_ack(spi_ack),
    .i_prd_en(prd_en), .o_prd_ack(prd_ack),
    .o_ack_status(ack_status), .o_ow_req(ow_req),
    .i_ow_ack(ow_ack), .i_ow_ack_status(ow_ack_status),
    .o_busy(busy), .o_tmo_err(tmo_err), .i_err_clr(err_clr)
  );

  int tests = 0, fails = 0, cyc = 0;
  int req_cyc[$];
  int ack_src[$];
  int ack_st[$];
  int ack_cyc[$];
  int busy_fall = -1, tmo_rise = -1;
  logic busy_prev = 1'b0, tmo_prev = 1'b0;
  // OW responder model
  bit resp_en = 1'b0;
  int resp_dly = 0;
  logic [31:0] resp_err_mask = '0;
  int resp_idx = 0;
  bit pend_ack = 1'b0;
  int ack_timer = 0;
  logic pend_st = 1'b0;

  // One cycle: sample outputs at negedge, log events, drive the next inputs
  task automatic cycle();
    @(negedge clk);
    cyc++;
    fsm_req = 1'b0; spi_req = 1'b0; ow_ack = 1'b0; ow_ack_status = 1'b0;
    if (ow_req) begin
      req_cyc.push_back(cyc);
      if (resp_en) begin
        pend_ack = 1'b1; ack_timer = resp_dly;
        pend_st = resp_err_mask[resp_idx[4:0]]; resp_idx++;
      end
    end
    if (fsm_ack) begin ack_src.push_back(0); ack_st.push_back(int'(ack_status)); ack_cyc.push_back(cyc); end
    if (spi_ack) begin ack_src.push_back(1); ack_st.push_back(int'(ack_status)); ack_cyc.push_back(cyc); end
    if (prd_ack) begin ack_src.push_back(2); ack_st.push_back(int'(ack_status)); ack_cyc.push_back(cyc); end
    if (fsm_ack || spi_ack || prd_ack)
      $display("[TB] cyc %0d ack fsm=%0b spi=%0b prd=%0b status=%0b", cyc, fsm_ack, spi_ack, prd_ack, ack_status);
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
    if (!tmo_prev && tmo_err) tmo_rise = cyc;
    tmo_prev = tmo_err;
    if (pend_ack) begin
      if (ack_timer == 0) begin
        ow_ack = 1'b1; ow_ack_status = pend_st; pend_ack = 1'b0;
      end else begin
        ack_timer--;
      end
    end
  endtask

  task automatic clear_logs();
    req_cyc.delete(); ack_src.delete(); ack_st.delete(); ack_cyc.delete();
    busy_fall = -1; tmo_rise = -1; resp_idx = 0; pend_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) cycle();
    tests++; if ({ow_req, busy, fsm_ack, spi_ack, prd_ack, ack_status, tmo_err} !== 7'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected 0000000", {ow_req, busy, fsm_ack, spi_ack, prd_ack, ack_status, tmo_err});
    end
    rst_n = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_single();
    int t;
    clear_logs(); resp_en = 1'b1; resp_dly = 5; resp_err_mask = '0;
    t = cyc; fsm_req = 1'b1;
    repeat (20) cycle();
    tests++; if (req_cyc.size() != 1 || req_cyc[0] != t + 2) begin
      fails++; $display("FAIL single_req_time: got %0d (n=%0d) expected %0d", (req_cyc.size() > 0) ? req_cyc[0] : -1, req_cyc.size(), t + 2);
    end
    tests++; if (ack_src.size() != 1 || ack_src[0] != 0 || ack_st[0] != 0) begin
      fails++; $display("FAIL single_ack: got n=%0d src=%0d st=%0d expected n=1 src=0 st=0", ack_src.size(), (ack_src.size() > 0) ? ack_src[0] : -1, (ack_st.size() > 0) ? ack_st[0] : -1);
    end
    tests++; if (ack_cyc.size() != 1 || ack_cyc[0] != t + 9) begin
      fails++; $display("FAIL single_ack_time: got %0d expected %0d", (ack_cyc.size() > 0) ? ack_cyc[0] : -1, t + 9);
    end
    tests++; if (busy_fall != t + 10) begin
      fails++; $display("FAIL single_busy_low: got %0d expected %0d", busy_fall, t + 10);
    end
  endtask

  task automatic test_ack_outside_wait();
    clear_logs(); resp_en = 1'b0;
    ow_ack = 1'b1; ow_ack_status = 1'b1;
    repeat (8) cycle();
    tests++; if (req_cyc.size() != 0 || ack_src.size() != 0 || busy !== 1'b0 || tmo_err !== 1'b0) begin
      fails++; $display("FAIL idle_ack_ignored: got reqs=%0d acks=%0d busy=%b tmo=%b expected 0 0 0 0", req_cyc.size(), ack_src.size(), busy, tmo_err);
    end
  endtask

  task automatic test_priority();
    int exp_n;
    clear_logs(); resp_en = 1'b1; resp_dly = 0; resp_err_mask = '0;
`ifdef LV_ADC_PRD_POLL_EN
    exp_n = 3;
    prd_en = 1'b1;
    repeat (17) cycle();
`else
    exp_n = 2;
`endif
    fsm_req = 1'b1; spi_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (ack_src.size() == 3) prd_en = 1'b0;
    end
    prd_en = 1'b0;
    tests++; if (ack_src.size() != exp_n || req_cyc.size() != exp_n) begin
      fails++; $display("FAIL prio_count: got acks=%0d reqs=%0d expected %0d", ack_src.size(), req_cyc.size(), exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      tests++; if (ack_src.size() <= i || ack_src[i] != i || ack_st[i] != 0) begin
        fails++; $display("FAIL prio_order[%0d]: got src=%0d st=%0d expected src=%0d st=0", i, (ack_src.size() > i) ? ack_src[i] : -1, (ack_st.size() > i) ? ack_st[i] : -1, i);
      end
    end
    tests++; if (req_cyc.size() < 2 || req_cyc[1] - req_cyc[0] != 3) begin
      fails++; $display("FAIL back_to_back_gap: got %0d expected 3", (req_cyc.size() > 1) ? req_cyc[1] - req_cyc[0] : -1);
    end
  endtask

  task automatic test_retry_exhaust();
    clear_logs(); resp_en = 1'b1; resp_dly = 1; resp_err_mask = '1;
    spi_req = 1'b1;
    repeat (40) cycle();
    tests++; if (req_cyc.size() != RETRY_NUM + 1) begin
      fails++; $display("FAIL retry_req_count: got %0d expected %0d", req_cyc.size(), RETRY_NUM + 1);
    end
    tests++; if (req_cyc.size() < 2 || req_cyc[1] - req_cyc[0] != 3) begin
      fails++; $display("FAIL retry_gap: got %0d expected 3", (req_cyc.size() > 1) ? req_cyc[1] - req_cyc[0] : -1);
    end
    tests++; if (ack_src.size() != 1 || ack_src[0] != 1 || ack_st[0] != 1) begin
      fails++; $display("FAIL retry_ack: got n=%0d src=%0d st=%0d expected n=1 src=1 st=1", ack_src.size(), (ack_src.size() > 0) ? ack_src[0] : -1, (ack_st.size() > 0) ? ack_st[0] : -1);
    end
    tests++; if (tmo_err !== 1'b0) begin
      fails++; $display("FAIL retry_no_tmo: got %b expected 0", tmo_err);
    end
  endtask

  task automatic test_retry_recover();
    clear_logs(); resp_en = 1'b1; resp_dly = 2; resp_err_mask = 32'h1;
    fsm_req = 1'b1;
    repeat (30) cycle();
    tests++; if (req_cyc.size() != 2 || ack_src.size() != 1 || ack_src[0] != 0 || ack_st[0] != 0) begin
      fails++; $display("FAIL retry_recover: got reqs=%0d acks=%0d st=%0d expected 2 1 0", req_cyc.size(), ack_src.size(), (ack_st.size() > 0) ? ack_st[0] : -1);
    end
  endtask

  task automatic test_timeout();
    clear_logs(); resp_en = 1'b0;
    spi_req = 1'b1;
    repeat (50) cycle();
    tests++; if (req_cyc.size() != RETRY_NUM + 1) begin
      fails++; $display("FAIL tmo_req_count: got %0d expected %0d", req_cyc.size(), RETRY_NUM + 1);
    end
    tests++; if (req_cyc.size() < 2 || req_cyc[1] - req_cyc[0] != ACK_TMO_CYC + 1) begin
      fails++; $display("FAIL tmo_gap: got %0d expected %0d", (req_cyc.size() > 1) ? req_cyc[1] - req_cyc[0] : -1, ACK_TMO_CYC + 1);
    end
    tests++; if (req_cyc.size() < 1 || tmo_rise != req_cyc[0] + ACK_TMO_CYC) begin
      fails++; $display("FAIL tmo_rise: got %0d expected %0d", tmo_rise, (req_cyc.size() > 0) ? req_cyc[0] + ACK_TMO_CYC : -1);
    end
    tests++; if (ack_src.size() != 1 || ack_src[0] != 1 || ack_st[0] != 1 || req_cyc.size() < 4 || ack_cyc[0] != req_cyc[3] + ACK_TMO_CYC + 1) begin
      fails++; $display("FAIL tmo_ack: got n=%0d src=%0d st=%0d cyc=%0d expected n=1 src=1 st=1 cyc=%0d", ack_src.size(), (ack_src.size() > 0) ? ack_src[0] : -1, (ack_st.size() > 0) ? ack_st[0] : -1, (ack_cyc.size() > 0) ? ack_cyc[0] : -1, (req_cyc.size() > 3) ? req_cyc[3] + ACK_TMO_CYC + 1 : -1);
    end
    tests++; if (tmo_err !== 1'b1) begin
      fails++; $display("FAIL tmo_sticky: got %b expected 1", tmo_err);
    end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    tests++; if (tmo_err !== 1'b0) begin
      fails++; $display("FAIL tmo_clear: got %b expected 0", tmo_err);
    end
  endtask

  task automatic test_err_clr_set_wins();
    logic v8 = 1'b0, v9 = 1'b1;
    clear_logs(); resp_en = 1'b0;
    err_clr = 1'b1; spi_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (req_cyc.size() > 0) begin
        if (cyc == req_cyc[0] + ACK_TMO_CYC) v8 = tmo_err;
        if (cyc == req_cyc[0] + ACK_TMO_CYC + 1) v9 = tmo_err;
      end
    end
    err_clr = 1'b0;
    tests++; if (v8 !== 1'b1) begin
      fails++; $display("FAIL set_wins_clr: got %b expected 1", v8);
    end
    tests++; if (v9 !== 1'b0 || tmo_err !== 1'b0) begin
      fails++; $display("FAIL held_clr: got %b/%b expected 0/0", v9, tmo_err);
    end
  endtask

`ifdef LV_ADC_PRD_POLL_EN
  task automatic test_periodic();
    int s, n;
    clear_logs(); resp_en = 1'b1; resp_dly = 0; resp_err_mask = '0;
    prd_en = 1'b0;
    cycle();
    s = cyc; prd_en = 1'b1;
    for (int i = 0; i < 200 && req_cyc.size() < 3; i++) cycle();
    tests++; if (req_cyc.size() < 1 || req_cyc[0] != s + PRD_CYC + 1) begin
      fails++; $display("FAIL prd_first: got %0d expected %0d", (req_cyc.size() > 0) ? req_cyc[0] : -1, s + PRD_CYC + 1);
    end
    tests++; if (req_cyc.size() < 3 || req_cyc[1] - req_cyc[0] != PRD_CYC + 3 || req_cyc[2] - req_cyc[1] != PRD_CYC + 3) begin
      fails++; $display("FAIL prd_period: got n=%0d gap=%0d expected gap %0d", req_cyc.size(), (req_cyc.size() > 1) ? req_cyc[1] - req_cyc[0] : -1, PRD_CYC + 3);
    end
    resp_dly = 3;
    for (int i = 0; i < 60 && req_cyc.size() < 4; i++) cycle();
    prd_en = 1'b0;
    repeat (80) cycle();
    n = 0;
    foreach (ack_src[i]) if (ack_src[i] == 2 && ack_st[i] == 0) n++;
    tests++; if (req_cyc.size() != 4 || n != 4 || ack_src.size() != 4) begin
      fails++; $display("FAIL prd_disable_inflight: got reqs=%0d prd_acks=%0d acks=%0d expected 4 4 4", req_cyc.size(), n, ack_src.size());
    end
  endtask
`else
  task automatic test_periodic();
    clear_logs(); prd_en = 1'b1;
    repeat (3 * PRD_CYC) cycle();
    prd_en = 1'b0;
    tests++; if (req_cyc.size() != 0 || ack_src.size() != 0 || prd_ack !== 1'b0) begin
      fails++; $display("FAIL prd_ignored: got reqs=%0d acks=%0d expected 0 0", req_cyc.size(), ack_src.size());
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    clear_logs(); resp_en = 1'b0;
    fsm_req = 1'b1;
    for (int i = 0; i < 10 && req_cyc.size() < 1; i++) cycle();
    cycle();
    tests++; if (busy !== 1'b1) begin
      fails++; $display("FAIL wait_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++; if ({ow_req, busy, fsm_ack, spi_ack, prd_ack, ack_status, tmo_err} !== 7'b0) begin
      fails++; $display("FAIL reset_async: got %b expected 0000000", {ow_req, busy, fsm_ack, spi_ack, prd_ack, ack_status, tmo_err});
    end
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    clear_logs();
    ow_ack = 1'b1;
    repeat (20) cycle();
    tests++; if (req_cyc.size() != 0 || ack_src.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_drops_pending: got reqs=%0d acks=%0d busy=%b expected 0 0 0", req_cyc.size(), ack_src.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ack_outside_wait();
    test_priority();
    test_retry_exhaust();
    test_retry_recover();
    test_timeout();
    test_err_clr_set_wins();
    test_periodic();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
